bmp_load_sequencer: RTL and testbench
=====================================

Name: bmp_load_sequencer

Overview:
- Top-level sequencer for loading a 24-bit BMP file from the SD card.
- Requests the file's first sector and drives the bitmap header checker's enable handshake.
- Walks the pixel array byte by byte, skipping row padding and requesting new sectors as byte positions cross sector boundaries.
- Presents each pixel byte's address within the sector buffer to a downstream pixel consumer through a valid/ready handshake.

Parameters:
SECTOR_LOG2, 9, log2 of sector size in bytes (512-byte sectors).
TIMEOUT_CYCLES, 1000000, watchdog limit per sector read (used only with the optional feature).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  level; rising edge or held high while in IDLE begins a load; must drop to clear done/fail
file_sector  in  32  first sector of the file, sampled when leaving IDLE
done  out  1  load complete; held while start high
fail  out  1  load failed; held while start high
sd_rd_req  out  1  sector read request; held until sd_rd_done or sd_rd_err
sd_rd_sector  out  32  sector to read; stable while sd_rd_req high
sd_rd_done  in  1  one-cycle pulse: sector is in the buffer
sd_rd_err  in  1  one-cycle pulse: read failed
hdr_check_en  out  1  enable to the header checker
hdr_complite  in  1  header check passed
hdr_fail  in  1  header check failed
pix_offset  in  16  pixel array offset from the header
pix_width  in  16  image width from the header
pix_height  in  16  image height from the header
pix_valid  out  1  pix_addr is valid
pix_ready  in  1  consumer accepts the byte
pix_addr  out  SECTOR_LOG2  byte address within the sector buffer
pix_comp  out  2  component index: 0=B, 1=G, 2=R
pix_last  out  1  final byte of the image

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0. Reset mid-operation aborts immediately and drops sd_rd_req and hdr_check_en in the same cycle.
- States: IDLE, RD_HDR, CHECK, RELEASE, INIT, SEEK, RD_PIX, EMIT, ADVANCE, DONE, FAIL.
- IDLE: on start = 1, latch file_sector and go to RD_HDR.
- RD_HDR: sd_rd_req = 1 with sd_rd_sector = file_sector.
  - sd_rd_done -> CHECK, loaded_sector <= file_sector.
  - sd_rd_err -> FAIL.
- CHECK: hdr_check_en = 1.
  - hdr_complite -> RELEASE (go_ok).
  - hdr_fail -> RELEASE (go_fail).
- RELEASE: hdr_check_en = 0 for exactly 1 cycle, then INIT or FAIL.
- INIT:
  - byte_pos (32b) <= pix_offset.
  - pad <= (4 - (pix_width*3 mod 4)) mod 4, computed at width 18b.
  - x <= 0, y <= 0, comp <= 0.
  - If pix_width == 0 or pix_height == 0 -> DONE with no pixel emitted.
- SEEK: tgt = file_sector + byte_pos[31:SECTOR_LOG2].
  - tgt == loaded_sector -> EMIT.
  - Otherwise -> RD_PIX.
- RD_PIX: request tgt.
  - sd_rd_done -> loaded_sector <= tgt, go to EMIT.
  - sd_rd_err -> FAIL.
- EMIT: pix_valid = 1, pix_addr = byte_pos[SECTOR_LOG2-1:0], pix_comp = comp.
  - pix_last = 1 when comp == 2, x == width-1, y == height-1.
  - Outputs held stable until pix_ready; on the valid & ready cycle go to ADVANCE.
- ADVANCE:
  - byte_pos += 1, comp += 1.
  - At comp == 2: comp <= 0, x += 1.
  - At row end: x <= 0, y += 1, byte_pos += 1 + pad.
  - After the last byte -> DONE; otherwise -> SEEK.
  - Sector crossing is handled per byte, so a pixel or padding run may straddle sectors.
- DONE / FAIL: done (or fail) = 1 while start = 1; when start = 0, clear the flag and return to IDLE.
- Simultaneous events:
  - sd_rd_done and sd_rd_err in the same cycle: err wins.
  - hdr_complite and hdr_fail in the same cycle: fail wins.
- Throughput: at most 1 byte per 3 cycles within a sector (EMIT/ADVANCE/SEEK).

Optional Feature:
- Macro: BMP_LOAD_TIMEOUT_EN.
- Defined: a 32-bit counter runs while sd_rd_req = 1 and clears on each new request. Reaching TIMEOUT_CYCLES drops sd_rd_req and goes to FAIL.
- Undefined: no counter; the block waits indefinitely for sd_rd_done or sd_rd_err.

Test Plan:
- Nominal load: file_sector = 100, header passes, width = 2, height = 2, offset = 54, ready always 1 -> exactly 1 read (sector 100).
  - pix_addr sequence: 54..59, then 62..67.
  - pix_comp sequence: 0,1,2,0,1,2 per row.
  - pix_last on addr 67; done = 1.
- Sector crossing: offset = 510, width = 1, height = 1 -> addrs 510 and 511 from sector 100, then read of sector 101, then addr 0 with pix_last; done = 1.
- Header fail: hdr_fail asserted in CHECK -> hdr_check_en drops for 1 cycle, fail = 1, no pix_valid. Dropping start clears fail and returns to IDLE.
- Backpressure and zero size:
  - pix_ready = 0 for 5 cycles in EMIT -> pix_addr and pix_comp stable, no byte skipped.
  - width = 0 -> done = 1 with no pix_valid.
- Read error / reset: sd_rd_err during RD_PIX -> fail = 1. rst asserted mid-EMIT -> all outputs 0 next cycle; a new start performs a full correct load.
- Timeout (BMP_LOAD_TIMEOUT_EN, TIMEOUT_CYCLES = 16): no sd_rd_done -> sd_rd_req drops and fail = 1 after 16 cycles.

Source files
------------

// File: rtl/bmp_load_sequencer.sv
// bmp_load_sequencer: reads a 24-bit BMP from SD, checks the header, then walks the pixel array
// byte by byte and hands sector-buffer addresses to a consumer. Define BMP_LOAD_TIMEOUT_EN for a read watchdog.
module bmp_load_sequencer #(
  parameter int SECTOR_LOG2    = 9,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [31:0]            file_sector,
  output logic                   done,
  output logic                   fail,
  output logic                   sd_rd_req,
  output logic [31:0]            sd_rd_sector,
  input  logic                   sd_rd_done,
  input  logic                   sd_rd_err,
  output logic                   hdr_check_en,
  input  logic                   hdr_complite,
  input  logic                   hdr_fail,
  input  logic [15:0]            pix_offset,
  input  logic [15:0]            pix_width,
  input  logic [15:0]            pix_height,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [SECTOR_LOG2-1:0] pix_addr,
  output logic [1:0]             pix_comp,
  output logic                   pix_last
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_RD_HDR, ST_CHECK, ST_RELEASE, ST_INIT, ST_SEEK,
    ST_RD_PIX, ST_EMIT, ST_ADVANCE, ST_DONE, ST_FAIL
  } state_t;

  state_t                 state_r, state_n;
  logic [31:0]            file_sector_r, loaded_sector_r, byte_pos_r;
  logic [15:0]            width_r, height_r, x_r, y_r;
  logic [1:0]             comp_r, pad_r;
  logic                   go_ok_r;
  logic [31:0]            tgt_s;
  logic [1:0]             w3_lsb_s, pad_s;
  logic                   last_s, timeout_s;
  logic                   sd_rd_req_n, hdr_check_en_n, pix_valid_n, pix_last_n, done_n, fail_n;
  logic [31:0]            sd_rd_sector_n;
  logic [SECTOR_LOG2-1:0] pix_addr_n;
  logic [1:0]             pix_comp_n;

  assign tgt_s    = file_sector_r + {{SECTOR_LOG2{1'b0}}, byte_pos_r[31:SECTOR_LOG2]};
  // Row padding only depends on (width*3) mod 4, so the low two bits suffice.
  assign w3_lsb_s = pix_width[1:0] * 2'd3;
  assign pad_s    = 2'd0 - w3_lsb_s;
  assign last_s   = (comp_r == 2'd2) && (x_r == width_r - 16'd1) && (y_r == height_r - 16'd1);

`ifdef BMP_LOAD_TIMEOUT_EN
  logic [31:0] tmo_cnt_r;

  // Watchdog: counts cycles of an outstanding read; requests are always separated by an idle cycle.
  always_ff @(posedge clk) begin
    if (rst || !sd_rd_req) begin
      tmo_cnt_r <= 32'd0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + 32'd1;
    end
  end

  assign timeout_s = sd_rd_req && (tmo_cnt_r == 32'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog compiled out: reads wait indefinitely.
  assign timeout_s = (TIMEOUT_CYCLES < 0);
`endif

  // Next-state decode; read error beats read done, header fail beats header pass.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE:    state_n = start ? ST_RD_HDR : ST_IDLE;
      ST_RD_HDR: begin
        if (sd_rd_err)       state_n = ST_FAIL;
        else if (sd_rd_done) state_n = ST_CHECK;
        else if (timeout_s)  state_n = ST_FAIL;
        else                 state_n = ST_RD_HDR;
      end
      ST_CHECK:   state_n = (hdr_fail || hdr_complite) ? ST_RELEASE : ST_CHECK;
      ST_RELEASE: state_n = go_ok_r ? ST_INIT : ST_FAIL;
      ST_INIT:    state_n = (pix_width == 16'd0 || pix_height == 16'd0) ? ST_DONE : ST_SEEK;
      ST_SEEK:    state_n = (tgt_s == loaded_sector_r) ? ST_EMIT : ST_RD_PIX;
      ST_RD_PIX: begin
        if (sd_rd_err)       state_n = ST_FAIL;
        else if (sd_rd_done) state_n = ST_EMIT;
        else if (timeout_s)  state_n = ST_FAIL;
        else                 state_n = ST_RD_PIX;
      end
      ST_EMIT:    state_n = pix_ready ? ST_ADVANCE : ST_EMIT;
      ST_ADVANCE: state_n = last_s ? ST_DONE : ST_SEEK;
      ST_DONE:    state_n = start ? ST_DONE : ST_IDLE;
      ST_FAIL:    state_n = start ? ST_FAIL : ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output can be registered.
  always_comb begin
    sd_rd_req_n    = 1'b0;
    sd_rd_sector_n = 32'd0;
    hdr_check_en_n = 1'b0;
    pix_valid_n    = 1'b0;
    pix_addr_n     = {SECTOR_LOG2{1'b0}};
    pix_comp_n     = 2'd0;
    pix_last_n     = 1'b0;
    done_n         = 1'b0;
    fail_n         = 1'b0;
    case (state_n)
      ST_RD_HDR: begin
        sd_rd_req_n    = 1'b1;
        sd_rd_sector_n = (state_r == ST_IDLE) ? file_sector : file_sector_r;
      end
      ST_RD_PIX: begin
        sd_rd_req_n    = 1'b1;
        sd_rd_sector_n = tgt_s;
      end
      ST_CHECK: hdr_check_en_n = 1'b1;
      ST_EMIT: begin
        pix_valid_n = 1'b1;
        pix_addr_n  = byte_pos_r[SECTOR_LOG2-1:0];
        pix_comp_n  = comp_r;
        pix_last_n  = last_s;
      end
      ST_DONE: done_n = 1'b1;
      ST_FAIL: fail_n = 1'b1;
      default: done_n = 1'b0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      sd_rd_req    <= 1'b0;
      sd_rd_sector <= 32'd0;
      hdr_check_en <= 1'b0;
      pix_valid    <= 1'b0;
      pix_addr     <= {SECTOR_LOG2{1'b0}};
      pix_comp     <= 2'd0;
      pix_last     <= 1'b0;
      done         <= 1'b0;
      fail         <= 1'b0;
    end else begin
      state_r      <= state_n;
      sd_rd_req    <= sd_rd_req_n;
      sd_rd_sector <= sd_rd_sector_n;
      hdr_check_en <= hdr_check_en_n;
      pix_valid    <= pix_valid_n;
      pix_addr     <= pix_addr_n;
      pix_comp     <= pix_comp_n;
      pix_last     <= pix_last_n;
      done         <= done_n;
      fail         <= fail_n;
    end
  end

  // Pixel walk datapath: file position, raster counters and loaded-sector tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      file_sector_r   <= 32'd0;
      loaded_sector_r <= 32'd0;
      byte_pos_r      <= 32'd0;
      width_r         <= 16'd0;
      height_r        <= 16'd0;
      x_r             <= 16'd0;
      y_r             <= 16'd0;
      comp_r          <= 2'd0;
      pad_r           <= 2'd0;
      go_ok_r         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: if (state_n == ST_RD_HDR) file_sector_r <= file_sector;
        ST_RD_HDR: if (state_n == ST_CHECK) loaded_sector_r <= file_sector_r;
        ST_CHECK: if (state_n == ST_RELEASE) go_ok_r <= ~hdr_fail;
        ST_INIT: begin
          byte_pos_r <= {16'd0, pix_offset};
          pad_r      <= pad_s;
          width_r    <= pix_width;
          height_r   <= pix_height;
          x_r        <= 16'd0;
          y_r        <= 16'd0;
          comp_r     <= 2'd0;
        end
        ST_RD_PIX: if (state_n == ST_EMIT) loaded_sector_r <= tgt_s;
        ST_ADVANCE: begin
          if (comp_r == 2'd2) begin
            comp_r <= 2'd0;
            if (x_r == width_r - 16'd1) begin
              x_r        <= 16'd0;
              y_r        <= y_r + 16'd1;
              byte_pos_r <= byte_pos_r + 32'd1 + {30'd0, pad_r};
            end else begin
              x_r        <= x_r + 16'd1;
              byte_pos_r <= byte_pos_r + 32'd1;
            end
          end else begin
            comp_r     <= comp_r + 2'd1;
            byte_pos_r <= byte_pos_r + 32'd1;
          end
        end
        default: go_ok_r <= go_ok_r;
      endcase
    end
  end

endmodule

// File: tb/tb_bmp_load_sequencer.sv
// Directed bench for bmp_load_sequencer: SD/header/consumer responders plus hand-computed byte streams.
module tb_bmp_load_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, sd_rd_done, sd_rd_err, hdr_complite, hdr_fail, pix_ready;
  logic [31:0] file_sector;
  logic [15:0] pix_offset, pix_width, pix_height;
  logic        done, fail, sd_rd_req, hdr_check_en, pix_valid, pix_last;
  logic [31:0] sd_rd_sector;
  logic [8:0]  pix_addr;
  logic [1:0]  pix_comp;

`ifdef BMP_LOAD_TIMEOUT_EN
  bmp_load_sequencer #(.SECTOR_LOG2(9), .TIMEOUT_CYCLES(16)) dut (
`else
  bmp_load_sequencer #(.SECTOR_LOG2(9)) dut (
`endif
    .clk(clk), .rst(rst), .start(start), .file_sector(file_sector),
    .done(done), .fail(fail), .sd_rd_req(sd_rd_req), .sd_rd_sector(sd_rd_sector),
    .sd_rd_done(sd_rd_done), .sd_rd_err(sd_rd_err), .hdr_check_en(hdr_check_en),
    .hdr_complite(hdr_complite), .hdr_fail(hdr_fail), .pix_offset(pix_offset),
    .pix_width(pix_width), .pix_height(pix_height), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_addr(pix_addr), .pix_comp(pix_comp), .pix_last(pix_last)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // responder configuration
  int rd_lat, err_read_idx, hdr_mode, stall_idx, stall_len;
  bit both_on_err, stop_on_valid;
  // observations
  int reads[$], addrs[$], comps[$], lasts[$];
  int exp_addr[$], exp_comp[$], exp_last[$];
  int min_gap, max_gap, req_cnt;
  bit finished, stable_ok;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_defaults();
    rd_lat = 2; err_read_idx = -1; both_on_err = 1'b0; hdr_mode = 0;
    stall_idx = -1; stall_len = 0; stop_on_valid = 1'b0;
  endtask

  task automatic run_load(input int sector, input int off, input int w, input int h, input int budget);
    bit prev_req = 1'b0;
    bit stalled = 1'b0;
    int stall_left = 0;
    int last_t = -1;
    int held_addr = 0;
    int held_comp = 0;
    reads.delete(); addrs.delete(); comps.delete(); lasts.delete();
    min_gap = 1000; max_gap = 0; req_cnt = 0; finished = 1'b0; stable_ok = 1'b1;
    file_sector = sector; pix_offset = 16'(off); pix_width = 16'(w); pix_height = 16'(h);
    pix_ready = 1'b1;
    start = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      sd_rd_done = 1'b0; sd_rd_err = 1'b0; hdr_complite = 1'b0; hdr_fail = 1'b0;
      if (done || fail) begin
        finished = 1'b1;
        break;
      end
      if (sd_rd_req) begin
        if (!prev_req) begin
          reads.push_back(sd_rd_sector);
          req_cnt = 0;
        end
        req_cnt++;
        if (req_cnt == rd_lat) begin
          if (reads.size() - 1 == err_read_idx) begin
            sd_rd_err = 1'b1;
            sd_rd_done = both_on_err;
          end else begin
            sd_rd_done = 1'b1;
          end
        end
      end
      prev_req = sd_rd_req;
      if (hdr_check_en) begin
        hdr_complite = 1'b1;
        hdr_fail = (hdr_mode != 0);
      end
      pix_ready = 1'b1;
      if (pix_valid) begin
        if (stop_on_valid) begin
          pix_ready = 1'b0;
          finished = 1'b1;
          break;
        end
        if (!stalled && addrs.size() == stall_idx) begin
          stalled = 1'b1; stall_left = stall_len; held_addr = pix_addr; held_comp = pix_comp;
        end
        if (stalled && (pix_addr != 9'(held_addr) || pix_comp != 2'(held_comp)))
          stable_ok = 1'b0;
        if (stall_left > 0) begin
          pix_ready = 1'b0;
          stall_left--;
        end else begin
          addrs.push_back(pix_addr); comps.push_back(pix_comp); lasts.push_back(pix_last);
          if (last_t >= 0) begin
            if (c - last_t < min_gap) min_gap = c - last_t;
            if (c - last_t > max_gap) max_gap = c - last_t;
          end
          last_t = c;
          stalled = 1'b0;
          stall_idx = -1;
        end
      end
    end
    check_val("run_finished_in_budget", finished, 1);
  endtask

  task automatic compare_stream(input string tag);
    check_val({tag, "_nbytes"}, addrs.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < addrs.size()) begin
        check_val($sformatf("%s_addr%0d", tag, i), addrs[i], exp_addr[i]);
        check_val($sformatf("%s_comp%0d", tag, i), comps[i], exp_comp[i]);
        check_val($sformatf("%s_last%0d", tag, i), lasts[i], exp_last[i]);
      end
    end
  endtask

  task automatic check_reads(input string tag, input int n, input int s0, input int s1);
    check_val({tag, "_nreads"}, reads.size(), n);
    if (reads.size() > 0) check_val({tag, "_rd0"}, reads[0], s0);
    if (reads.size() > 1 && n > 1) check_val({tag, "_rd1"}, reads[1], s1);
  endtask

  task automatic end_load(input string tag, input logic exp_done, input logic exp_fail);
    check_val({tag, "_done"}, done, exp_done);
    check_val({tag, "_fail"}, fail, exp_fail);
    repeat (3) @(negedge clk);
    check_val({tag, "_held"}, {done, fail}, {exp_done, exp_fail});
    start = 1'b0;
    @(negedge clk);
    check_val({tag, "_clear"}, {done, fail, sd_rd_req, pix_valid}, 4'b0000);
    @(negedge clk);
  endtask

  task automatic set_nominal_exp();
    exp_addr = '{54, 55, 56, 57, 58, 59, 62, 63, 64, 65, 66, 67};
    exp_comp = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2};
    exp_last = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sd_rd_done = 1'b0; sd_rd_err = 1'b0;
    hdr_complite = 1'b0; hdr_fail = 1'b0; pix_ready = 1'b1;
    file_sector = 32'd0; pix_offset = 16'd0; pix_width = 16'd0; pix_height = 16'd0;
    set_defaults();
    repeat (3) @(negedge clk);
    check_val("reset_ctrl", {done, fail, sd_rd_req, hdr_check_en, pix_valid, pix_last, pix_comp}, 8'd0);
    check_val("reset_addr", {sd_rd_sector, pix_addr} == 41'd0, 1);
    rst = 1'b0;
    @(negedge clk);

    // nominal 2x2 image, 2 padding bytes per row, ready always high
    set_nominal_exp();
    run_load(100, 54, 2, 2, 300);
    check_reads("nom", 1, 100, 0);
    compare_stream("nom");
    check_val("nom_min_gap", min_gap, 3);
    check_val("nom_max_gap", max_gap, 3);
    end_load("nom", 1'b1, 1'b0);

    // pixel straddling a sector boundary
    exp_addr = '{510, 511, 0}; exp_comp = '{0, 1, 2}; exp_last = '{0, 0, 1};
    run_load(100, 510, 1, 1, 300);
    check_reads("cross", 2, 100, 101);
    compare_stream("cross");
    end_load("cross", 1'b1, 1'b0);

    // header pass and fail asserted together: fail wins
    hdr_mode = 1;
    exp_addr.delete(); exp_comp.delete(); exp_last.delete();
    run_load(100, 54, 2, 2, 300);
    check_reads("hdrfail", 1, 100, 0);
    compare_stream("hdrfail");
    end_load("hdrfail", 1'b0, 1'b1);
    set_defaults();

    // consumer stalls 5 cycles on the fourth byte
    stall_idx = 3; stall_len = 5;
    set_nominal_exp();
    run_load(100, 54, 2, 2, 300);
    compare_stream("stall");
    check_val("stall_stable", stable_ok, 1);
    end_load("stall", 1'b1, 1'b0);
    set_defaults();

    // zero width: done without any pixel
    exp_addr.delete(); exp_comp.delete(); exp_last.delete();
    run_load(100, 54, 0, 3, 300);
    check_reads("zero", 1, 100, 0);
    compare_stream("zero");
    end_load("zero", 1'b1, 1'b0);

    // pixel-sector read reports done and err together: err wins
    err_read_idx = 1; both_on_err = 1'b1;
    exp_addr = '{510, 511}; exp_comp = '{0, 1}; exp_last = '{0, 0};
    run_load(100, 510, 1, 1, 300);
    check_reads("rderr", 2, 100, 101);
    compare_stream("rderr");
    end_load("rderr", 1'b0, 1'b1);
    set_defaults();

    // reset while a byte is being presented, then a clean reload
    stop_on_valid = 1'b1;
    run_load(100, 54, 2, 2, 300);
    check_val("rst_pre_valid", pix_valid, 1);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    check_val("rst_mid_ctrl", {done, fail, sd_rd_req, hdr_check_en, pix_valid, pix_last, pix_comp}, 8'd0);
    check_val("rst_mid_addr", pix_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    set_defaults();
    set_nominal_exp();
    run_load(100, 54, 2, 2, 300);
    check_reads("reload", 1, 100, 0);
    compare_stream("reload");
    end_load("reload", 1'b1, 1'b0);

`ifdef BMP_LOAD_TIMEOUT_EN
    // card never answers: request held 16 cycles, then fail
    rd_lat = 100000;
    exp_addr.delete(); exp_comp.delete(); exp_last.delete();
    run_load(100, 54, 2, 2, 300);
    check_reads("tmo", 1, 100, 0);
    check_val("tmo_req_cycles", req_cnt, 16);
    end_load("tmo", 1'b0, 1'b1);
    set_defaults();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
